// File: rtl/signed_vector_vector_division.sv
// Three-lane iterative sign-magnitude divider: 28 restoring steps after acceptance, then DONE.
// Operands accepted only in IDLE; the result is held in DONE until out_ready, with no new accept meanwhile.
module signed_vector_vector_division #(
    parameter int SCALAR_WIDTH = 19,
    parameter int FRAC_BITS    = 10,
    parameter int VECTOR_WIDTH = 57
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [VECTOR_WIDTH-1:0] in_vector_1,
    input  logic [VECTOR_WIDTH-1:0] in_vector_2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [VECTOR_WIDTH-1:0] out_vector,
    output logic [2:0]              div_by_zero,
    output logic [2:0]              overflow
);
    localparam int MAG_W = SCALAR_WIDTH - 1;
    localparam int DIV_W = MAG_W + FRAC_BITS;
    localparam int CNT_W = $clog2(DIV_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_W - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                      state_q, state_d;
    logic [2:0]                  sign_q, sign_d;
    logic [2:0][DIV_W-1:0]       dividend_q, dividend_d;
    logic [2:0][MAG_W-1:0]       divisor_q, divisor_d;
    logic [2:0][MAG_W-1:0]       rem_q, rem_d;
    logic [2:0][DIV_W-1:0]       quo_q, quo_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [VECTOR_WIDTH-1:0]     out_vec_q, out_vec_d;
    logic [2:0]                  dbz_q, dbz_d;
    logic [2:0]                  ovf_q, ovf_d;

    logic [2:0][MAG_W:0]         rem_shift;
    logic [2:0][MAG_W:0]         rem_diff;
    logic [2:0]                  qbit;
    logic [2:0][MAG_W-1:0]       res_mag;

    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        out_vec_d  = out_vec_q;
        dbz_d      = dbz_q;
        ovf_d      = ovf_q;
        rem_shift  = '0;
        rem_diff   = '0;
        qbit       = '0;
        res_mag    = '0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    for (int l = 0; l < 3; l++) begin
                        sign_d[l]     = in_vector_1[l*SCALAR_WIDTH + MAG_W]
                                      ^ in_vector_2[l*SCALAR_WIDTH + MAG_W];
                        dividend_d[l] = {in_vector_1[l*SCALAR_WIDTH +: MAG_W], {FRAC_BITS{1'b0}}};
                        divisor_d[l]  = in_vector_2[l*SCALAR_WIDTH +: MAG_W];
                    end
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int l = 0; l < 3; l++) begin
                    rem_shift[l] = {rem_q[l], dividend_q[l][DIV_W-1]};
                    rem_diff[l]  = rem_shift[l] - {1'b0, divisor_q[l]};
                    qbit[l]      = (rem_shift[l] >= {1'b0, divisor_q[l]});
                    rem_d[l]     = qbit[l] ? rem_diff[l][MAG_W-1:0] : rem_shift[l][MAG_W-1:0];
                    quo_d[l]     = (quo_q[l] << 1) | DIV_W'(qbit[l]);
                    dividend_d[l] = dividend_q[l] << 1;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    // Zero divisor takes priority: its all-ones quotient must not raise overflow.
                    for (int l = 0; l < 3; l++) begin
                        dbz_d[l] = 1'b0;
                        ovf_d[l] = 1'b0;
                        if (divisor_q[l] == '0) begin
                            res_mag[l] = '1;
                            dbz_d[l]   = 1'b1;
                        end else if (quo_d[l][DIV_W-1:MAG_W] != '0) begin
                            res_mag[l] = '1;
                            ovf_d[l]   = 1'b1;
                        end else begin
                            res_mag[l] = quo_d[l][MAG_W-1:0];
                        end
                        out_vec_d[l*SCALAR_WIDTH +: SCALAR_WIDTH] = {sign_q[l], res_mag[l]};
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sign_q     <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            out_vec_q  <= '0;
            dbz_q      <= '0;
            ovf_q      <= '0;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            out_vec_q  <= out_vec_d;
            dbz_q      <= dbz_d;
            ovf_q      <= ovf_d;
        end
    end

    assign in_ready    = (state_q == IDLE) & ~rst;
    assign out_valid   = (state_q == DONE);
    assign out_vector  = out_vec_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;
endmodule
